// File: rtl/seg_pkg.sv
// Shared types and constants for the scrolling seven-segment driver.
// Segment table entries are a..g with 1 = lit; outputs are inverted later.
package seg_pkg;

    typedef enum logic [1:0] {
        SEG_BLANK  = 2'd0,
        SEG_STATIC = 2'd1,
        SEG_SCROLL = 2'd2,
        SEG_BLINK  = 2'd3
    } seg_mode_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble plus dp to active-low segment byte.
// Output bit7..bit1 = a..g, bit0 = dp.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = ~{SEG_HEX[nib], dp};

endmodule

// File: rtl/seg_scroll_disp.sv
// Parametrised seven-segment driver with blank/static/scroll/blink modes.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scroll_disp
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 5000000,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic [1:0]              in_mode,
    output logic [8*NUM_DIGITS-1:0] o_seg,
    output logic                    busy
);

    localparam int OFF_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(NUM_DIGITS - 1);

    seg_mode_t               state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [OFF_W-1:0]        offset;
    logic                    phase;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [8*NUM_DIGITS-1:0] seg_q, seg_nxt;
    logic [63:0]             data_pad;
    logic [15:0]             dp_pad;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    tick, load;

    assign tick     = (cnt == CNT_W'(CLK_DIV - 1));
    assign busy     = (state == SEG_SCROLL) && (offset != '0);
    assign in_ready = !busy;
    assign load     = in_valid && in_ready;
    assign o_seg    = seg_q;
    assign data_pad = 64'(data_q);
    assign dp_pad   = 16'(dp_q);

    always_comb begin
        state_nxt = state;
        if (load) state_nxt = seg_mode_t'(in_mode);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= SEG_BLANK;
            cnt    <= '0;
            offset <= '0;
            phase  <= 1'b0;
            data_q <= '0;
            dp_q   <= '0;
            seg_q  <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            state <= state_nxt;
            seg_q <= seg_nxt;
            if (load) begin
                cnt    <= '0;
                offset <= '0;
                phase  <= 1'b1;
                data_q <= in_data;
                dp_q   <= in_dp;
            end else begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
                if (tick && state == SEG_SCROLL)
                    offset <= (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);
                if (tick && state == SEG_BLINK)
                    phase <= ~phase;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // lz[i]: nibbles i..top are all zero; digit 0 never blanks
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = (data_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            lz[i] = lz[i+1] && (data_q[4*i +: 4] == 4'h0);
        lz_blank = '0;
        if (state == SEG_STATIC || state == SEG_BLINK)
            lz_blank = {lz[NUM_DIGITS-1:1], 1'b0} & ~NUM_DIGITS'(1);
    end
`else
    assign lz_blank = '0;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [4:0] sum;
        logic [3:0] src;
        logic [7:0] dec, show;
        logic       dark;

        always_comb begin
            sum = 5'(g) + 5'(offset);
            if (sum >= 5'(NUM_DIGITS)) sum = sum - 5'(NUM_DIGITS);
        end
        assign src = sum[3:0];

        seg_hex_decode u_dec (
            .nib (data_pad[{src, 2'b00} +: 4]),
            .dp  (dp_pad[src]),
            .seg (dec)
        );

        assign show = lz_blank[g] ? {7'h7F, ~dp_pad[src]} : dec;
        assign dark = (state == SEG_BLANK) ||
                      (state == SEG_BLINK && !phase);
        assign seg_nxt[8*g +: 8] = dark ? SEG_OFF : show;
    end

endmodule

// File: tb/tb_seg_scroll_disp.sv
// Directed self-checking bench for seg_scroll_disp (8 digits, CLK_DIV = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg_scroll_disp;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [7:0]  in_dp = '0;
    logic [1:0]  in_mode = '0;
    logic [63:0] o_seg;
    logic        busy;
    logic [63:0] exp_seg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scroll_disp #(
        .NUM_DIGITS (8),
        .CLK_DIV    (4),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dp    (in_dp),
        .in_mode  (in_mode),
        .o_seg    (o_seg),
        .busy     (busy)
    );

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [63:0] model(input logic [31:0] d,
                                          input logic [7:0] dp,
                                          input int off, input bit lz);
        logic [63:0] r;
        int src;
        bit blank;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            src = (i + off) % 8;
            blank = LZB && lz && (i != 0) && ((d >> (4 * i)) == 32'd0);
            r[8*i +: 8] = blank ? {7'h7F, ~dp[src]}
                                : ~{seg7(d[4*src +: 4]), dp[src]};
        end
        return r;
    endfunction

    task automatic load(input logic [31:0] d, input logic [7:0] dp,
                        input logic [1:0] m);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_dp    = dp;
        in_mode  = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}}) begin
            errors++;
            $display("FAIL reset_seg_held: got %h expected all ones", o_seg);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}}) begin
            errors++;
            $display("FAIL reset_seg: got %h expected all ones", o_seg);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ready=%b busy=%b expected 1 0",
                     in_ready, busy);
        end
    endtask

    task automatic test_static;
        load(32'h0123ABCD, 8'h01, 2'd1);
        @(negedge clk);
        checks++;
        if (o_seg[7:0] !== 8'h84) begin
            errors++;
            $display("FAIL static_d0: got %h expected 84", o_seg[7:0]);
        end
        checks++;
        if (o_seg[63:56] !== (LZB ? 8'hFF : 8'h03)) begin
            errors++;
            $display("FAIL static_d7: got %h expected %h",
                     o_seg[63:56], LZB ? 8'hFF : 8'h03);
        end
        exp_seg = model(32'h0123ABCD, 8'h01, 0, 1'b1);
        checks++;
        if (o_seg !== exp_seg) begin
            errors++;
            $display("FAIL static_full: got %h expected %h", o_seg, exp_seg);
        end
        load(32'hFEDCBA98, 8'hAA, 2'd1);
        @(negedge clk);
        exp_seg = model(32'hFEDCBA98, 8'hAA, 0, 1'b1);
        checks++;
        if (o_seg !== exp_seg) begin
            errors++;
            $display("FAIL static_full2: got %h expected %h", o_seg, exp_seg);
        end
    endtask

    task automatic test_blank;
        load(32'h12345678, 8'hFF, 2'd0);
        @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}}) begin
            errors++;
            $display("FAIL blank: got %h expected all ones", o_seg);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h11111111;
        in_dp    = 8'h00;
        in_mode  = 2'd1;
        @(negedge clk);
        in_data  = 32'h22222222;
        in_dp    = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        exp_seg = model(32'h11111111, 8'h00, 0, 1'b1);
        checks++;
        if (o_seg !== exp_seg) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", o_seg, exp_seg);
        end
        @(negedge clk);
        exp_seg = model(32'h22222222, 8'h80, 0, 1'b1);
        checks++;
        if (o_seg !== exp_seg) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", o_seg, exp_seg);
        end
    endtask

    task automatic test_scroll;
        load(32'h76543210, 8'h81, 2'd2);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL scroll_start: got busy=%b ready=%b expected 0 1",
                     busy, in_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (o_seg[7:0] !== 8'h9F || o_seg[63:56] !== 8'h02) begin
            errors++;
            $display("FAIL scroll_tick1: got d0=%h d7=%h expected 9f 02",
                     o_seg[7:0], o_seg[63:56]);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL scroll_busy: got busy=%b ready=%b expected 1 0",
                     busy, in_ready);
        end
        repeat (6) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        in_dp    = 8'hFF;
        in_mode  = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        exp_seg = model(32'h76543210, 8'h81, 3, 1'b0);
        checks++;
        if (o_seg !== exp_seg) begin
            errors++;
            $display("FAIL scroll_ignore_load: got %h expected %h",
                     o_seg, exp_seg);
        end
        repeat (18) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL scroll_off7: got ready=%b busy=%b expected 0 1",
                     in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL scroll_wrap: got ready=%b busy=%b expected 1 0",
                     in_ready, busy);
        end
        @(negedge clk);
        exp_seg = model(32'h76543210, 8'h81, 0, 1'b0);
        checks++;
        if (o_seg !== exp_seg) begin
            errors++;
            $display("FAIL scroll_full_turn: got %h expected %h",
                     o_seg, exp_seg);
        end
        @(negedge clk);
        // this load lands on the same edge as the ninth tick
        load(32'h89ABCDEF, 8'h10, 2'd2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tick_load_offset: got busy=%b expected 0", busy);
        end
        @(negedge clk);
        exp_seg = model(32'h89ABCDEF, 8'h10, 0, 1'b0);
        checks++;
        if (o_seg !== exp_seg || o_seg[7:0] !== 8'h71) begin
            errors++;
            $display("FAIL tick_load_unrot: got %h expected %h",
                     o_seg, exp_seg);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || o_seg !== exp_seg) begin
            errors++;
            $display("FAIL tick_load_t4: got busy=%b seg=%h expected 1 %h",
                     busy, o_seg, exp_seg);
        end
        @(negedge clk);
        exp_seg = model(32'h89ABCDEF, 8'h10, 1, 1'b0);
        checks++;
        if (o_seg !== exp_seg) begin
            errors++;
            $display("FAIL tick_load_rot1: got %h expected %h",
                     o_seg, exp_seg);
        end
    endtask

    task automatic test_reset_mid;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}} || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got seg=%h ready=%b busy=%b expected ff.. 1 0",
                     o_seg, in_ready, busy);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}}) begin
            errors++;
            $display("FAIL reset_mid_after: got %h expected all ones", o_seg);
        end
    endtask

    task automatic test_blink;
        logic [63:0] on5, onA;
        on5 = model(32'h00000005, 8'h00, 0, 1'b1);
        onA = model(32'h0000000A, 8'h01, 0, 1'b1);
        load(32'h00000005, 8'h00, 2'd3);
        @(negedge clk);
        checks++;
        if (o_seg !== on5 || o_seg[7:0] !== 8'h49) begin
            errors++;
            $display("FAIL blink_on1: got %h expected %h", o_seg, on5);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_seg !== on5) begin
            errors++;
            $display("FAIL blink_on4: got %h expected %h", o_seg, on5);
        end
        @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}}) begin
            errors++;
            $display("FAIL blink_off5: got %h expected all ones", o_seg);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}}) begin
            errors++;
            $display("FAIL blink_off8: got %h expected all ones", o_seg);
        end
        @(negedge clk);
        checks++;
        if (o_seg !== on5) begin
            errors++;
            $display("FAIL blink_on9: got %h expected %h", o_seg, on5);
        end
        // reload mid-period; the stale tick must not toggle the new phase
        load(32'h0000000A, 8'h01, 2'd3);
        repeat (3) @(negedge clk);
        checks++;
        if (o_seg !== onA) begin
            errors++;
            $display("FAIL blink_prescale_restart: got %h expected %h",
                     o_seg, onA);
        end
        @(negedge clk);
        checks++;
        if (o_seg !== onA) begin
            errors++;
            $display("FAIL blink_reload_on4: got %h expected %h", o_seg, onA);
        end
        @(negedge clk);
        checks++;
        if (o_seg !== {64{1'b1}}) begin
            errors++;
            $display("FAIL blink_reload_off5: got %h expected all ones", o_seg);
        end
    endtask

`ifdef SEG_LEADING_ZERO_BLANK_EN
    task automatic test_lzb;
        load(32'h00000000, 8'h00, 2'd1);
        @(negedge clk);
        checks++;
        if (o_seg[63:8] !== {56{1'b1}} || o_seg[7:0] !== 8'h03) begin
            errors++;
            $display("FAIL lzb_zero: got %h expected ff..ff03", o_seg);
        end
        load(32'h00050000, 8'h80, 2'd1);
        @(negedge clk);
        checks++;
        if (o_seg !== 64'hFEFF_FF49_0303_0303) begin
            errors++;
            $display("FAIL lzb_dp: got %h expected feffff4903030303", o_seg);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_static();
        test_blank();
        test_back_to_back();
        test_scroll();
        test_reset_mid();
        test_blink();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scroll_disp.md
Name: seg_scroll_disp

Overview:
Parametrised successor of the fixed 8-digit seven-segment driver. It drives NUM_DIGITS active-low seven-segment digits from a loaded hex word, with full 0-F decode and per-digit decimal points. Four display modes are supported: blank, static, scroll (rotate) and blink, all timed by an internal prescaler. It sits between the core's debug/MMIO write path (valid/ready load) and the board segment pins.

Parameters:
NUM_DIGITS, 8, number of digits driven; legal range 1..16.
CLK_DIV, 5000000, clk cycles per display tick; must be >= 2.
CNT_W, 32, prescaler counter width; must hold CLK_DIV-1.

Ports:
clk  input  1  system clock
rst  input  1  reset
in_valid  input  1  load request
in_ready  output  1  block can accept a load this cycle
in_data  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
in_dp  input  NUM_DIGITS  decimal-point enable per digit, 1 = lit
in_mode  input  2  0 = BLANK, 1 = STATIC, 2 = SCROLL, 3 = BLINK
o_seg  output  8*NUM_DIGITS  digit i on bits [8i+7:8i]; bit7..bit1 = segments a..g, bit0 = dp; active-low
busy  output  1  high while a scroll rotation is in progress

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst = 0 sampled at a clk edge resets the block.
- Reset values: o_seg all ones (all segments dark), in_ready = 1, busy = 0, state = BLANK, prescaler = 0, offset = 0, blink phase = 0, data and dp registers = 0.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick = 1 for one cycle when count == CLK_DIV-1. The prescaler restarts at 0 on every accepted load.
- Load: accepted when in_valid && in_ready at a clk edge. The edge captures in_data, in_dp and in_mode, sets offset = 0 and blink phase = 1 (on).
- in_ready = 0 only in the SCROLL state while offset != 0. A scroll always completes a full rotation before the next load is accepted.
- busy = (state == SCROLL) && (offset != 0).
- States, selected by the loaded in_mode:
  - BLANK: all outputs dark.
  - STATIC: digit i shows nibble i.
  - SCROLL: digit i shows nibble (i + offset) mod NUM_DIGITS. Each tick increments offset, wrapping from NUM_DIGITS-1 to 0. Rotation continues indefinitely; a new load is accepted only at offset == 0.
  - BLINK: each tick toggles the phase. Phase 1 shows the STATIC pattern; phase 0 is all dark.
- Transitions occur only on an accepted load; the state becomes the loaded mode.
- The dp bit follows the loaded dp of the displayed nibble's source position. In SCROLL the dp rotates with its digit.
- Hex decode (a..g, 1 = lit):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- o_seg is fully registered. A load accepted at edge N is visible on o_seg after edge N+1; a tick at edge N is also visible after edge N+1.
- Simultaneous tick and accepted load: the load wins, and that tick is discarded.
- NUM_DIGITS = 1 in SCROLL: offset stays 0, so the display behaves as STATIC and in_ready stays 1.
- Reset mid-scroll or mid-blink returns everything to the reset values at that edge.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN.
- Defined: in STATIC and BLINK-on, zero digits above the most significant nonzero nibble are dark, except that digit 0 always shows. dp still shows on a blanked digit if that dp is set. SCROLL is unaffected.
- Undefined: all digits are always decoded.

Decomposition:
- Package seg_pkg holds:
  - the mode enum (SEG_BLANK, SEG_STATIC, SEG_SCROLL, SEG_BLINK);
  - the 16-entry hex-to-segment constant table;
  - the SEG_OFF constant (8'hFF).
- Sub-module seg_hex_decode: 4-bit nibble plus dp in, active-low 8-bit segment byte out, purely combinational, instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, then release -> o_seg = all 1s, in_ready = 1, busy = 0.
- STATIC load with NUM_DIGITS = 8: in_data = 32'h0123ABCD, in_dp = 8'h01 -> after 2 edges, digit0 = ~8'b01111011 (d with dp lit) and digit7 = ~8'b11111100 (0, dp dark).
- SCROLL with CLK_DIV = 4, in_data = 32'h76543210:
  - after the first tick, digit0 shows 1;
  - in_ready = 0 and busy = 1 until 8 ticks (32 cycles) have elapsed, then in_ready = 1;
  - a load attempted at tick 3 is ignored.
- BLINK with CLK_DIV = 4, in_data = 32'h00000005 -> o_seg alternates between the STATIC pattern and all 1s every 4 cycles.
- Load on the same edge as a tick in SCROLL -> offset = 0, the prescaler restarts, and the new data is shown unrotated.
- With SEG_LEADING_ZERO_BLANK_EN defined and in_data = 32'h00000000 (STATIC) -> digits 7..1 all 1s, digit0 = ~8'b11111100.
